// File: rtl/cpu_core.sv
// 8-bit accumulator CPU with a 16-bit address space, driven by a multi-cycle fetch/execute FSM.
// The external RAM is synchronous: a byte addressed in one cycle arrives on i_di in the next.
module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_addr,
  input  logic [7:0]  i_di,
  output logic [7:0]  o_do,
  output logic        o_we
);

  typedef enum logic [2:0] {S_F0, S_F1, S_I1, S_A1, S_A2, S_M1, S_HALT} state_t;

  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_LDA = 8'h02;
  localparam logic [7:0] OP_STA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h05;
  localparam logic [7:0] OP_AND = 8'h06;
  localparam logic [7:0] OP_OR  = 8'h07;
  localparam logic [7:0] OP_XOR = 8'h08;
  localparam logic [7:0] OP_JMP = 8'h09;
  localparam logic [7:0] OP_JZ  = 8'h0A;
  localparam logic [7:0] OP_JC  = 8'h0B;
  localparam logic [7:0] OP_HLT = 8'h0C;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_a;
  logic [7:0]  r_ir;
  logic [7:0]  r_lo;
  logic        r_z;
  logic        r_c;

  logic [15:0] w_ea;
  logic        w_di_op16;
  logic        w_ir_load;
  logic [7:0]  w_alu;
  logic        w_alu_c;

  assign w_ea      = {i_di, r_lo};
  assign w_di_op16 = (i_di >= OP_LDA) && (i_di <= OP_JC);
  assign w_ir_load = (r_ir == OP_LDA) || ((r_ir >= OP_ADD) && (r_ir <= OP_XOR));

  // Only LDA/ALU and STA put the effective address on the bus; everything else shows PC.
  always_comb begin
    o_addr = r_pc;
    if ((r_state == S_A2) && ((r_ir == OP_STA) || w_ir_load)) o_addr = w_ea;
  end

  // rst gates the store combinationally so a reset landing on A2 can never corrupt memory.
  assign o_we = !rst && (r_state == S_A2) && (r_ir == OP_STA);
  assign o_do = o_we ? r_a : 8'h00;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu   = i_di;
    w_alu_c = r_c;
    case (r_ir)
      OP_ADD: {w_alu_c, w_alu} = {1'b0, r_a} + {1'b0, i_di};
      OP_SUB: begin
        w_alu   = r_a - i_di;
        w_alu_c = (r_a < i_di);
      end
      OP_AND: begin
        w_alu   = r_a & i_di;
        w_alu_c = 1'b0;
      end
      OP_OR: begin
        w_alu   = r_a | i_di;
        w_alu_c = 1'b0;
      end
      OP_XOR: begin
        w_alu   = r_a ^ i_di;
        w_alu_c = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_F0;
      r_pc    <= RESET_PC;
      r_a     <= 8'h00;
      r_ir    <= 8'h00;
      r_lo    <= 8'h00;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        S_F0: begin
          r_pc    <= r_pc + 16'd1;
          r_state <= S_F1;
        end
        S_F1: begin
          r_ir <= i_di;
          if (i_di == OP_HLT) begin
            r_state <= S_HALT;
          end else if (i_di == OP_LDI) begin
            r_pc    <= r_pc + 16'd1;
            r_state <= S_I1;
          end else if (w_di_op16) begin
            r_pc    <= r_pc + 16'd1;
            r_state <= S_A1;
          end else begin
            r_state <= S_F0;
          end
        end
        S_I1: begin
          r_a     <= i_di;
          r_z     <= (i_di == 8'h00);
          r_state <= S_F0;
        end
        S_A1: begin
          r_lo    <= i_di;
          r_pc    <= r_pc + 16'd1;
          r_state <= S_A2;
        end
        S_A2: begin
          r_state <= w_ir_load ? S_M1 : S_F0;
          case (r_ir)
            OP_JMP:  r_pc <= w_ea;
            OP_JZ:   if (r_z) r_pc <= w_ea;
            OP_JC:   if (r_c) r_pc <= w_ea;
            default: ;
          endcase
        end
        S_M1: begin
          r_a     <= w_alu;
          r_c     <= w_alu_c;
          r_z     <= (w_alu == 8'h00);
          r_state <= S_F0;
        end
        S_HALT: ;
        default: r_state <= S_F0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: an instruction-level reference model predicts the fetch address and
// store activity of every cycle, which is compared against the DUT on a behavioural RAM.
module tb_cpu_core;

  localparam int          MAXC     = 1024;
  localparam int          HOLD     = 24;
  localparam int          ASZ      = MAXC + HOLD + 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] o_addr;
  logic [7:0]  i_di;
  logic [7:0]  o_do;
  logic        o_we;

  logic [7:0]  mem [0:65535];
  logic [7:0]  mm  [0:65535];

  int n_cmp  = 0;
  int n_fail = 0;

  bit          exp_we    [0:ASZ];
  logic [15:0] exp_waddr [0:ASZ];
  logic [7:0]  exp_wdata [0:ASZ];
  bit          exp_fv    [0:ASZ];
  logic [15:0] exp_fetch [0:ASZ];
  logic [15:0] obs_addr  [0:ASZ];
  logic        obs_we    [0:ASZ];
  logic [7:0]  obs_do    [0:ASZ];
  int          halt_cyc;
  logic [15:0] halt_pc;
  int          last_cyc;

  cpu_core #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .o_addr (o_addr),
    .i_di   (i_di),
    .o_do   (o_do),
    .o_we   (o_we)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data lags the address by one cycle, writes land on the edge.
  always @(posedge clk) begin
    i_di <= mem[o_addr];
    if (o_we) mem[o_addr] = o_do;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  // Bytes are listed first-to-last from the most significant end of the vector.
  task automatic load(input logic [15:0] base, input int n, input logic [255:0] bytes);
    logic [15:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      mem[a] = bytes[8*(n-1-i) +: 8];
      a = a + 16'd1;
    end
  endtask

  // Executes the program one instruction at a time, charging each its architectural cycle count.
  task automatic build_model(input int limit);
    logic [15:0] pc, ea, lo_a, hi_a;
    logic [7:0]  a, op, v;
    logic [8:0]  s;
    logic        z, c;
    int          cyc;
    for (int i = 0; i < 65536; i++) mm[i] = mem[i];
    for (int i = 0; i <= ASZ; i++) begin
      exp_we[i] = 1'b0; exp_waddr[i] = '0; exp_wdata[i] = '0;
      exp_fv[i] = 1'b0; exp_fetch[i] = '0;
    end
    pc = RESET_PC; a = 8'h00; z = 1'b0; c = 1'b0; cyc = 1;
    halt_cyc = -1; halt_pc = '0;
    while (cyc <= limit && halt_cyc < 0) begin
      exp_fv[cyc] = 1'b1;
      exp_fetch[cyc] = pc;
      op = mm[pc];
      pc = pc + 16'd1;
      if (op == 8'h0C) begin
        halt_cyc = cyc;
        halt_pc  = pc;
      end else if (op == 8'h01) begin
        a = mm[pc]; pc = pc + 16'd1; z = (a == 8'h00); cyc += 3;
      end else if (op >= 8'h02 && op <= 8'h0B) begin
        lo_a = pc; hi_a = pc + 16'd1;
        ea = {mm[hi_a], mm[lo_a]};
        pc = pc + 16'd2;
        v  = mm[ea];
        case (op)
          8'h03: begin
            exp_we[cyc+3] = 1'b1; exp_waddr[cyc+3] = ea; exp_wdata[cyc+3] = a;
            mm[ea] = a;
          end
          8'h09: pc = ea;
          8'h0A: if (z) pc = ea;
          8'h0B: if (c) pc = ea;
          8'h02: a = v;
          8'h04: begin s = a + v; a = s[7:0]; c = s[8]; end
          8'h05: begin c = (a < v); a = a - v; end
          8'h06: begin a = a & v; c = 1'b0; end
          8'h07: begin a = a | v; c = 1'b0; end
          default: begin a = a ^ v; c = 1'b0; end
        endcase
        if (op == 8'h02 || (op >= 8'h04 && op <= 8'h08)) begin
          z = (a == 8'h00);
          cyc += 5;
        end else begin
          cyc += 4;
        end
      end else begin
        cyc += 2;
      end
    end
    last_cyc = (halt_cyc >= 0) ? halt_cyc + HOLD : limit;
  endtask

  task automatic run_prog(input string tag, input int limit);
    build_model(limit);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " reset we"}, o_we, 1'b0);
    check({tag, " reset do"}, o_do, 8'h00);
    check({tag, " reset addr"}, o_addr, RESET_PC);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      obs_addr[cyc] = o_addr;
      obs_we[cyc]   = o_we;
      obs_do[cyc]   = o_do;
      check($sformatf("%s c%0d we", tag, cyc), o_we, exp_we[cyc]);
      if (exp_we[cyc]) begin
        check($sformatf("%s c%0d st addr", tag, cyc), o_addr, exp_waddr[cyc]);
        check($sformatf("%s c%0d st do", tag, cyc), o_do, exp_wdata[cyc]);
      end else begin
        check($sformatf("%s c%0d do", tag, cyc), o_do, 8'h00);
      end
      if (exp_fv[cyc]) check($sformatf("%s c%0d fetch", tag, cyc), o_addr, exp_fetch[cyc]);
      if (halt_cyc >= 0 && cyc > halt_cyc)
        check($sformatf("%s c%0d halt addr", tag, cyc), o_addr, halt_pc);
    end
  endtask

  task automatic gen_random();
    int          n, r, len;
    int          st [0:40];
    logic [7:0]  opc [0:39];
    logic [15:0] a, t;
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      mem[16'h8000 + i] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
    end
    n = $urandom_range(8, 30);
    st[0] = 0;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 14);
      opc[i] = (r <= 11) ? 8'(r) : 8'($urandom_range(13, 255));
      len = (opc[i] == 8'h01) ? 2 : (opc[i] >= 8'h02 && opc[i] <= 8'h0B) ? 3 : 1;
      st[i+1] = st[i] + len;
    end
    for (int i = 0; i < n; i++) begin
      a = 16'(st[i]);
      mem[a] = opc[i];
      if (opc[i] == 8'h01) begin
        r = $urandom_range(0, 2);
        mem[a + 16'd1] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      end else if (opc[i] >= 8'h09 && opc[i] <= 8'h0B) begin
        t = 16'(st[$urandom_range(i + 1, n)]);
        mem[a + 16'd1] = t[7:0];
        mem[a + 16'd2] = t[15:8];
      end else if (opc[i] >= 8'h02 && opc[i] <= 8'h08) begin
        mem[a + 16'd1] = 8'($urandom_range(0, 15));
        mem[a + 16'd2] = 8'h80;
      end
    end
    mem[16'(st[n])] = 8'h0C;
  endtask

  initial begin
    rst = 1'b1;

    // LDI 5; STA 0x0100; HLT -- the store must fall in cycle 7.
    clear_mem();
    load(16'h0000, 6, 256'h01_05_03_00_01_0C);
    run_prog("sta", 200);
    check("sta c7 we", obs_we[7], 1'b1);
    check("sta c7 addr", obs_addr[7], 16'h0100);
    check("sta c7 do", obs_do[7], 8'h05);
    check("sta ram", mem[16'h0100], 8'h05);

    // FF+FF through memory: A=FE, C=1, Z=0 (JZ falls through, JC taken).
    clear_mem();
    load(16'h0000, 21, 256'h01_FF_03_00_02_02_00_02_04_00_02_03_01_02_0A_50_00_0B_30_00_0C);
    mem[16'h0030] = 8'h0C;
    mem[16'h0050] = 8'h0C;
    run_prog("add", 300);
    check("add result", mem[16'h0201], 8'hFE);
    check("add halt pc", obs_addr[last_cyc], 16'h0031);

    // Reset must clear A, Z and C left over from the previous program.
    clear_mem();
    load(16'h0000, 10, 256'h03_20_01_0A_40_00_0B_40_00_0C);
    mem[16'h0040] = 8'h0C;
    run_prog("rstval", 200);
    check("rstval A stored", obs_do[4], 8'h00);
    check("rstval st we", obs_we[4], 1'b1);
    check("rstval halt pc", obs_addr[last_cyc], 16'h000A);

    // 3-3 sets Z, clears C; JZ taken to 0x40, JC there falls through to 0x43.
    clear_mem();
    load(16'h0000, 9, 256'h01_03_05_00_03_0A_40_00_0C);
    load(16'h0040, 7, 256'h0B_60_00_03_10_02_0C);
    mem[16'h0060] = 8'h0C;
    mem[16'h0300] = 8'h03;
    mem[16'h0210] = 8'h5A;
    run_prog("sub", 300);
    check("sub jz target", obs_addr[13], 16'h0040);
    check("sub jc fallthru", obs_addr[17], 16'h0043);
    check("sub store A", mem[16'h0210], 8'h00);
    check("sub halt pc", obs_addr[last_cyc], 16'h0047);

    // PC wrap during immediate and operand fetch, plus an undefined opcode.
    clear_mem();
    load(16'h0000, 4, 256'h09_FD_FF_0C);
    load(16'hFFFD, 3, 256'h01_42_03);
    run_prog("wrap", 300);
    check("wrap st addr", obs_addr[11], 16'hFD09);
    check("wrap ram", mem[16'hFD09], 8'h42);
    check("wrap next fetch", obs_addr[12], 16'h0002);
    check("wrap halt pc", obs_addr[last_cyc], 16'h0004);

    // HLT at 0x0010 holds the bus at 0x0011; reset restarts fetch at 0x0000.
    clear_mem();
    mem[16'h0010] = 8'h0C;
    run_prog("hlt", 300);
    check("hlt start", halt_cyc, 33);
    check("hlt hold addr", obs_addr[last_cyc], 16'h0011);
    check("hlt hold we", obs_we[last_cyc], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("hlt restart addr", o_addr, 16'h0000);

    // Reset landing on A2 of a store: no write, PC back to 0.
    clear_mem();
    load(16'h0000, 6, 256'h01_05_03_00_01_0C);
    mem[16'h0100] = 8'hAA;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstA2 we", o_we, 1'b0);
    check("rstA2 do", o_do, 8'h00);
    @(negedge clk);
    check("rstA2 we mid", o_we, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstA2 ram", mem[16'h0100], 8'hAA);
    check("rstA2 pc", o_addr, 16'h0000);

    for (int k = 0; k < 20; k++) begin
      gen_random();
      run_prog($sformatf("rnd%0d", k), 600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
